uvmt_mem_st_mem_rspdr: RTL and testbench
========================================

UVMT_MEM_ST_MEM_RSPDR -- requirements
Module: uvmt_mem_st_mem_rspdr

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the memory size in 32-bit words; it SHALL be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response FIFO entry; legal range is 1..4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: initiator request valid.
REQ-006 The block SHALL have port gnt, output, 1 bit: request grant; a transfer is accepted when req && gnt.
REQ-007 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port be, input, 4 bits: byte enables for writes.
REQ-009 The block SHALL have port addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port rvalid, output, 1 bit: response valid.
REQ-012 The block SHALL have port rready, input, 1 bit: response accepted when rvalid && rready.
REQ-013 The block SHALL have port rdata, output, 32 bits: read data; 0 for writes.
REQ-014 The block SHALL have port err, output, 1 bit: error flag qualified by rvalid.

Function
REQ-015 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] is ignored.
REQ-016 An accepted write SHALL update only the bytes selected by be, at the clock edge of acceptance.
REQ-017 An accepted read SHALL sample memory at acceptance, so a read accepted the cycle after a write to the same word returns the new data.
REQ-018 Each accepted request SHALL enter a LATENCY-stage pipeline carrying {rdata, err}, then push into a 4-entry response FIFO.
REQ-019 The response to a request accepted at edge T SHALL be visible on rvalid/rdata no earlier than cycle T+LATENCY; responses SHALL leave in acceptance order.
REQ-020 rvalid SHALL equal FIFO not-empty, and rdata/err SHALL show the FIFO head.
REQ-021 The head SHALL pop on rvalid && rready; rdata/err SHALL hold stable while rvalid && !rready.
REQ-022 A 3-bit credit counter SHALL track in-flight pipeline entries plus FIFO entries.
  - Increment on accept.
  - Decrement on pop.
  - Unchanged when accept and pop occur in the same cycle.
REQ-023 gnt SHALL be 1 iff credits < 4 and reset is low; gnt depends only on registered state, never on req.
REQ-024 FIFO overflow SHALL be impossible by construction; behaviour of pop on an empty FIFO is don't-care, since pop requires rvalid.
REQ-025 With credits == 4 and a pop in the current cycle, gnt SHALL still be 0 that cycle and become 1 the next cycle.

Reset
REQ-026 While reset is high, the block SHALL drive gnt=0, rvalid=0, rdata=0 and err=0.
REQ-027 While reset is high, the block SHALL clear credits, pipeline valids and FIFO pointers.
REQ-028 gnt SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued responses.
REQ-030 Memory contents SHALL NOT be reset; writes already accepted SHALL persist.

Configuration
REQ-031 The block SHALL support macro UVMT_MEM_ST_MEM_RSPDR_ERR_EN.
REQ-032 With UVMT_MEM_ST_MEM_RSPDR_ERR_EN defined, an address >= DEPTH*4 SHALL return err=1 and rdata=0.
  - Such a write SHALL leave memory unchanged.
  - Such a request SHALL still consume a credit and receive its response in order.
REQ-033 Without UVMT_MEM_ST_MEM_RSPDR_ERR_EN, addresses SHALL wrap modulo DEPTH*4 and err SHALL be tied 0.

Verification
REQ-034 Write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 in the next cycle, LATENCY=2, rready=1 -> write response rdata=0, err=0; read response rdata=0xDEADBEEF, rvalid high 2 cycles after the read is accepted.
REQ-035 Starting from 0xDEADBEEF at 0x10, write 0x00AA0000 to 0x10 with be=0x4, then read 0x10 -> rdata=0xDEADBEEF with byte 2 replaced by 0xAA (0xDEAABEEF).
REQ-036 Hold req=1 and rready=0, issue 6 reads -> exactly 4 accepted, gnt=0 from then on; raise rready -> 4 in-order responses; gnt reasserts the cycle after the first pop.
REQ-037 Keep req=1 and rready=1 continuously with LATENCY=1 -> one accept and one pop per cycle, gnt stays 1, credits never exceed 2.
REQ-038 Assert reset 1 cycle with 3 responses queued -> rvalid=0 next cycle and gnt=1; a subsequent read of a previously written word returns the written data.
REQ-039 With UVMT_MEM_ST_MEM_RSPDR_ERR_EN defined and DEPTH=256, write to 0x400 then read 0x0 -> write response err=1; word 0 unchanged. Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/uvmt_mem_st_mem_rspdr.sv
// Single-port word memory responder with a fixed-latency response pipeline and 4-entry response FIFO.
// Optional macro UVMT_MEM_ST_MEM_RSPDR_ERR_EN flags out-of-range addresses instead of wrapping them.
module uvmt_mem_st_mem_rspdr #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        gnt,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0]        mem [DEPTH];
  logic [2:0]         credits;
  logic               accept;
  logic               pop;
  logic               push;
  logic               oob;
  logic [AW-1:0]      idx;
  rsp_t               acc_rsp;
  logic [LATENCY-1:0] pipe_vld;
  rsp_t               pipe_rsp [LATENCY];
  rsp_t               fifo [4];
  logic [2:0]         wr_ptr;
  logic [2:0]         rd_ptr;
  rsp_t               head;
  logic               fifo_empty;

  // Credits bound pipeline plus FIFO occupancy to 4, so the FIFO can never overflow.
  assign gnt    = !reset && (credits < 3'd4);
  assign accept = req && gnt;
  assign pop    = rvalid && rready;
  assign idx    = addr[AW+1:2];

`ifdef UVMT_MEM_ST_MEM_RSPDR_ERR_EN
  logic unused_addr;
  assign oob         = |addr[31:AW+2];
  assign unused_addr = ^addr[1:0];
`else
  logic unused_addr;
  assign oob         = 1'b0;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

  // Response for the request being accepted this cycle; reads see all earlier writes.
  always_comb begin
    acc_rsp = '0;
    if (!we && !oob) acc_rsp.data = mem[idx];
    acc_rsp.err = oob;
  end

  // NOTE: memory contents are deliberately not reset, so accepted writes survive a reset.
  always_ff @(posedge clk) begin
    if (accept && we && !oob) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits + 3'd1;
        2'b01:   credits <= credits - 3'd1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_rsp[0] <= acc_rsp;
    for (int i = 1; i < LATENCY; i++) pipe_rsp[i] <= pipe_rsp[i-1];
  end

  assign push = pipe_vld[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[1:0]] <= pipe_rsp[LATENCY-1];
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = fifo[rd_ptr[1:0]];
  assign rvalid     = !reset && !fifo_empty;
  assign rdata      = rvalid ? head.data : 32'h0;
  assign err        = rvalid && head.err;

endmodule

// File: tb/tb_uvmt_mem_st_mem_rspdr.sv
// Scoreboard bench: drivers push expected responses at acceptance, monitors pop and compare.
// Instance u_dut uses LATENCY=2; u_dut1 uses LATENCY=1 for the streaming check.
module tb_uvmt_mem_st_mem_rspdr;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, rready;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        req1, we1, rready1;
  logic [3:0]  be1;
  logic [31:0] addr1, wdata1;
  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc1_n = 0;
  int          pop1_n = 0;
  exp_t        q[$];
  exp_t        q1[$];
  logic [31:0] model  [256];
  logic [31:0] model1 [256];

  uvmt_mem_st_mem_rspdr #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .err(err)
  );

  uvmt_mem_st_mem_rspdr #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .gnt(gnt1), .we(we1), .be(be1),
    .addr(addr1), .wdata(wdata1), .rvalid(rvalid1), .rready(rready1),
    .rdata(rdata1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted request on the LATENCY=2 instance.
  task automatic model_accept(input logic w, input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] d, input bit exact);
    int unsigned wi;
    logic        e;
    exp_t        x;
    wi = (a >> 2) % 256;
`ifdef UVMT_MEM_ST_MEM_RSPDR_ERR_EN
    e = (a >= 32'd1024);
`else
    e = 1'b0;
`endif
    x.err = e; x.acc = cyc; x.exact = exact;
    if (w) begin
      if (!e) for (int k = 0; k < 4; k++) if (b[k]) model[wi][8*k +: 8] = d[8*k +: 8];
      x.data = 32'h0;
    end else begin
      x.data = e ? 32'h0 : model[wi];
    end
    q.push_back(x);
  endtask

  // Drive one request until granted; returns one step after the accepting edge.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input bit exact);
    bit got;
    // NOTE: bench inputs are driven with blocking assignments just after the edge, never at it.
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      got = gnt;
      @(posedge clk); #1;
      if (got) break;
    end
    if (got) model_accept(w, b, a, d, exact);
    else check("issue_timeout", 32'(got), 32'd1);
    req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && q1.size() == 0) break;
    end
    if (n == 100) check("drain_timeout", 32'(q.size() + q1.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        check("rdata", rdata, q[0].data);
        check("err", 32'(err), 32'(q[0].err));
        if (rready) begin
          if (q[0].exact) check("latency", 32'(cyc - q[0].acc), 32'd2);
          void'(q.pop_front());
        end
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (!reset && rvalid1 && rready1) begin
      if (q1.size() == 0) begin
        check("unexpected_rsp1", 32'd1, 32'd0);
      end else begin
        check("rdata1", rdata1, q1[0].data);
        check("err1", 32'(err1), 32'(q1[0].err));
        void'(q1.pop_front());
        pop1_n++;
      end
    end
  end

  initial begin
    logic [31:0] rd_list [6];
    int          k, naccept;
    bit          g;
    exp_t        x;

    reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; rready = 1'b1;
    req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = '0; wdata1 = '0; rready1 = 1'b1;

    // Outputs held inactive during reset; grant returns the first cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("gnt_after_rst", 32'(gnt), 32'd1);
    @(posedge clk); #1;

    // Write then read the same word back-to-back; read response exactly 2 cycles later.
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
    wait_drain();

    // Partial write of byte 2 only; addr[1:0] ignored on the read.
    issue(1'b1, 4'h4, 32'h10, 32'h00AA0000, 1'b0);
    issue(1'b0, 4'h0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h20, 32'h11111111, 1'b0);
    issue(1'b1, 4'hF, 32'h24, 32'h22222222, 1'b0);
    issue(1'b1, 4'h3, 32'h28, 32'h3333FFFF, 1'b0);
    issue(1'b1, 4'hC, 32'h28, 32'hA5A50000, 1'b0);
    wait_drain();

    // Back-pressure: 6 read attempts with rready=0, only 4 may be accepted.
    rd_list[0] = 32'h10; rd_list[1] = 32'h20; rd_list[2] = 32'h24;
    rd_list[3] = 32'h28; rd_list[4] = 32'h10; rd_list[5] = 32'h20;
    rready = 1'b0;
    k = 0; naccept = 0;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = rd_list[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = gnt;
      check("bp_gnt", 32'(g), (i < 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (g) begin
        model_accept(1'b0, 4'h0, rd_list[k], 32'h0, 1'b0);
        naccept++;
        k++;
        addr = rd_list[k];
      end
    end
    req = 1'b0;
    check("bp_accepts", 32'(naccept), 32'd4);
    rready = 1'b1;
    @(negedge clk);
    check("gnt_pop_cycle", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("gnt_after_pop", 32'(gnt), 32'd1);
    wait_drain();

    // Reset with 3 responses queued discards them; memory survives.
    rready = 1'b0;
    issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h24, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h28, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    check("postrst_rvalid", 32'(rvalid), 32'd0);
    check("postrst_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    rready = 1'b1;
    issue(1'b0, 4'h0, 32'h28, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    wait_drain();

    // Out-of-range address: error response, or wrap into word 0 in the default build.
    issue(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(1'b1, 4'hF, 32'h400, 32'h12345678, 1'b0);
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h404, 32'h0, 1'b0);
    wait_drain();

    // LATENCY=1 streaming: one accept and one pop per cycle, at most 2 outstanding.
    req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      we1 = (i < 8); be1 = 4'hF;
      addr1 = 32'((i % 8) * 4);
      wdata1 = 32'h10000000 + 32'(i) * 32'h01010101;
      @(negedge clk);
      check("stream_gnt", 32'(gnt1), 32'd1);
      if (i >= 2) check("stream_rvalid", 32'(rvalid1), 32'd1);
      @(posedge clk); #1;
      if (gnt1 !== 1'bx) begin
        x.err = 1'b0; x.acc = cyc; x.exact = 1'b0;
        if (i < 8) begin
          model1[i] = 32'h10000000 + 32'(i) * 32'h01010101;
          x.data = 32'h0;
        end else begin
          x.data = model1[i - 8];
        end
        q1.push_back(x);
        acc1_n++;
      end
      if (acc1_n - pop1_n > 2) check("stream_credits", 32'(acc1_n - pop1_n), 32'd2);
    end
    req1 = 1'b0;
    wait_drain();

    check("q_empty", 32'(q.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
